// File: rtl/add8u_err_char_if.sv
// Bundle of the characterizer's control, DUT-operand and result signals.
// master: the characterizer. slave: the environment that owns the DUT adder
// and the start pulse.
interface add8u_err_char_if #(
  parameter int W = 8
);
  logic             start;
  logic             busy;
  logic             done;
  logic [W-1:0]     dut_a;
  logic [W-1:0]     dut_b;
  logic [W:0]       dut_o;
  logic [3*W:0]     sum_abs_err;
  logic [W:0]       wce;
  logic [2*W:0]     err_cnt;
  logic [4*W+1:0]   sum_sq_err;

  modport master (
    input  start, dut_o,
    output busy, done, dut_a, dut_b, sum_abs_err, wce, err_cnt, sum_sq_err
  );

  modport slave (
    output start, dut_o,
    input  busy, done, dut_a, dut_b, sum_abs_err, wce, err_cnt, sum_sq_err
  );
endinterface

// File: rtl/add8u_err_char.sv
// Exhaustive error characterizer for W-bit unsigned approximate adders.
// Sweeps every (A,B) pair into an external adder, compares its W+1-bit sum
// with the exact sum DUT_LAT cycles later and accumulates |err| sum, worst
// case error and error count. Define ADD_ERR_SQ_EN to also build the
// squared-error accumulator; otherwise sum_sq_err is tied to zero.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// SWEEP   | issuing one operand pair per cycle
// DRAIN   | operands finished, waiting for the last compares to land
// DONE    | results valid and frozen, start begins a new sweep
module add8u_err_char #(
  parameter int W       = 8,
  parameter int DUT_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  add8u_err_char_if.master  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int DW = $clog2(DUT_LAT + 2);

  logic [1:0]       state_q, state_d;
  logic [2*W-1:0]   idx_q, idx_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W:0]       exact_q [DUT_LAT+1];
  logic [W:0]       exact_d [DUT_LAT+1];
  logic [DUT_LAT:0] vld_q, vld_d;
  logic [3*W:0]     sae_q, sae_d;
  logic [W:0]       wce_q, wce_d;
  logic [2*W:0]     cnt_q, cnt_d;

  logic             accept;
  logic             cmp_vld;
  logic [W:0]       err;

  assign accept  = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  assign cmp_vld = vld_q[DUT_LAT];

  // Absolute difference between the DUT sum and the aligned exact sum.
  always_comb begin
    err = '0;
    if (bus.dut_o >= exact_q[DUT_LAT]) err = bus.dut_o - exact_q[DUT_LAT];
    else                               err = exact_q[DUT_LAT] - bus.dut_o;
  end

  // Sequencer, operand issue, alignment pipeline and accumulators.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    a_d     = a_q;
    b_d     = b_q;
    exact_d = exact_q;
    vld_d   = vld_q;
    sae_d   = sae_q;
    wce_d   = wce_q;
    cnt_d   = cnt_q;

    // The exact sum and valid bit follow the operands through the DUT.
    for (int i = 1; i <= DUT_LAT; i++) begin
      exact_d[i] = exact_q[i-1];
      vld_d[i]   = vld_q[i-1];
    end
    vld_d[0] = 1'b0;

    if (cmp_vld) begin
      sae_d = sae_q + (3*W+1)'(err);
      if (err > wce_q) wce_d = err;
      if (err != '0)   cnt_d = cnt_q + (2*W+1)'(1);
    end

    case (state_q)
      S_SWEEP: begin
        a_d        = idx_q[W-1:0];
        b_d        = idx_q[2*W-1:W];
        exact_d[0] = {1'b0, idx_q[W-1:0]} + {1'b0, idx_q[2*W-1:W]};
        vld_d[0]   = 1'b1;
        idx_d      = idx_q + 1'b1;
        if (&idx_q) begin
          state_d = S_DRAIN;
          drain_d = DW'(DUT_LAT + 1);
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - 1'b1;
      end
      default: begin
        if (accept) begin
          state_d = S_SWEEP;
          idx_d   = '0;
          vld_d   = '0;
          sae_d   = '0;
          wce_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      exact_q <= '{default: '0};
      vld_q   <= '0;
      sae_q   <= '0;
      wce_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exact_q <= exact_d;
      vld_q   <= vld_d;
      sae_q   <= sae_d;
      wce_q   <= wce_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ADD_ERR_SQ_EN
  logic [2*W+1:0] err_sq;
  logic [4*W+1:0] sq_q, sq_d;

  assign err_sq = (2*W+2)'(err) * (2*W+2)'(err);

  // Squared-error accumulator, cleared with the others on start.
  always_comb begin
    sq_d = sq_q;
    if (cmp_vld) sq_d = sq_q + (4*W+2)'(err_sq);
    if (accept)  sq_d = '0;
  end

  // Squared-error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sq_q <= '0;
    else        sq_q <= sq_d;
  end

  assign bus.sum_sq_err = sq_q;
`else
  assign bus.sum_sq_err = '0;
`endif

  assign bus.busy        = (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.dut_a       = a_q;
  assign bus.dut_b       = b_q;
  assign bus.sum_abs_err = sae_q;
  assign bus.wce         = wce_q;
  assign bus.err_cnt     = cnt_q;
endmodule
